step_scheduler: RTL and testbench

Pattern-driven step scheduler for the drum sequencer. It holds a TRACKS × STEPS on/off pattern and advances a step pointer at a run-time-programmable tempo. At each step it issues one-cycle trigger pulses and fixed-length gates to the voice generators (square-wave and sample voices) for every track that is active on that step. It sits between the user-interface/pattern-edit logic and the voice/mixer datapath.

---
 rtl/seq_pkg.sv | 19 +
 rtl/gate_timer.sv | 29 ++
 rtl/step_scheduler.sv | 127 ++++++++++++
 tb/tb_step_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the drum step scheduler.
// Holds the FSM state encoding and the tempo clamp helper.
package seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int TEMPO_W       = 24;
   localparam int MIN_TICKS_DEF = 16;

   // A step must last at least lo clocks so trig/strobe never merge into a level.
   function automatic logic [TEMPO_W-1:0] clamp_tempo(input logic [TEMPO_W-1:0] t,
                                                      input logic [TEMPO_W-1:0] lo);
      return (t < lo) ? lo : t;
   endfunction

endpackage

// File: rtl/gate_timer.sv
// Per-track gate: high for GATE_CYCLES clocks starting with the load cycle.
// A load while high restarts the count, so the gate stays high across retriggers.
module gate_timer #(
   parameter int GATE_CYCLES = 2_500_000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic clear,
   input  logic load,
   output logic gate
);

   localparam int CW = $clog2(GATE_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(GATE_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign gate = (cnt != '0);

endmodule

// File: rtl/step_scheduler.sv
// Pattern-driven step scheduler: TRACKS x STEPS pattern, programmable tempo,
// one-cycle triggers and fixed-length gates per active track.
module step_scheduler
   import seq_pkg::*;
#(
   parameter int STEPS       = 16,
   parameter int TRACKS      = 4,
   parameter int GATE_CYCLES = 2_500_000,
   parameter int MIN_TICKS   = MIN_TICKS_DEF
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      run,
   input  logic [TEMPO_W-1:0]        tempo_ticks,
   input  logic                      wr_en,
   input  logic [$clog2(TRACKS)-1:0] wr_track,
   input  logic [$clog2(STEPS)-1:0]  wr_step,
   input  logic                      wr_val,
   input  logic [$clog2(STEPS)-1:0]  rd_step,
   output logic [TRACKS-1:0]         rd_col,
   output logic [$clog2(STEPS)-1:0]  step_idx,
   output logic                      step_strobe,
   output logic [TRACKS-1:0]         trig,
   output logic [TRACKS-1:0]         gate,
   output logic                      playing
);

   localparam int SW = $clog2(STEPS);

   state_t                   state, state_nx;
   logic [TEMPO_W-1:0]       tick_cnt, tempo_lat;
   logic [TRACKS-1:0][STEPS-1:0] pattern;
   logic                     start, advance, stop;
   logic [SW-1:0]            next_step;
   logic [TRACKS-1:0]        trig_nx;

   // Stop has priority over a step boundary falling in the same cycle.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      advance  = 1'b0;
      stop     = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_nx = RUN;
               start    = 1'b1;
            end
         end
         RUN: begin
            if (!run) begin
               state_nx = IDLE;
               stop     = 1'b1;
            end else if (tick_cnt == tempo_lat - TEMPO_W'(1)) begin
               advance = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Triggers read the pattern before this edge's write lands.
   always_comb begin
      next_step = start ? '0 : step_idx + SW'(1);
      trig_nx   = '0;
      for (int t = 0; t < TRACKS; t++) begin
         trig_nx[t] = (start | advance) & pattern[t][next_step];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         tick_cnt    <= '0;
         tempo_lat   <= TEMPO_W'(MIN_TICKS);
         step_idx    <= '0;
         step_strobe <= 1'b0;
         trig        <= '0;
      end else begin
         step_strobe <= start | advance;
         trig        <= trig_nx;
         if (start || advance) begin
            tick_cnt  <= '0;
            step_idx  <= next_step;
            tempo_lat <= clamp_tempo(tempo_ticks, TEMPO_W'(MIN_TICKS));
         end else if (state == RUN && !stop) begin
            tick_cnt <= tick_cnt + TEMPO_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pattern <= '0;
         rd_col  <= '0;
      end else begin
         if (wr_en) begin
            pattern[wr_track][wr_step] <= wr_val;
         end
         for (int t = 0; t < TRACKS; t++) begin
            rd_col[t] <= pattern[t][rd_step];
         end
      end
   end

   assign playing = (state == RUN);

   for (genvar t = 0; t < TRACKS; t++) begin : g_gate
      gate_timer #(
         .GATE_CYCLES(GATE_CYCLES)
      ) u_gate (
         .CLOCK_50(CLOCK_50),
         .reset   (reset),
         .clear   (stop),
         .load    (trig_nx[t]),
         .gate    (gate[t])
      );
   end

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_step_scheduler;

   localparam int STEPS  = 4;
   localparam int TRACKS = 2;
   localparam int G1     = 3;
   localparam int G2     = 6;
   localparam int MINT   = 4;
   localparam int SW     = 2;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b1;
   logic              run = 1'b0;
   logic [23:0]       tempo_ticks = 24'd10;
   logic              wr_en = 1'b0;
   logic [0:0]        wr_track = '0;
   logic [SW-1:0]     wr_step = '0;
   logic              wr_val = 1'b0;
   logic [SW-1:0]     rd_step = '0;

   logic [TRACKS-1:0] rd_col, trig, gate;
   logic [SW-1:0]     step_idx;
   logic              step_strobe, playing;
   logic [TRACKS-1:0] rd_col_b, trig_b, gate_b;
   logic [SW-1:0]     step_idx_b;
   logic              step_strobe_b, playing_b;

   always #10 CLOCK_50 = ~CLOCK_50;

   step_scheduler #(.STEPS(STEPS), .TRACKS(TRACKS), .GATE_CYCLES(G1), .MIN_TICKS(MINT)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .tempo_ticks(tempo_ticks),
      .wr_en(wr_en), .wr_track(wr_track), .wr_step(wr_step), .wr_val(wr_val),
      .rd_step(rd_step), .rd_col(rd_col), .step_idx(step_idx), .step_strobe(step_strobe),
      .trig(trig), .gate(gate), .playing(playing)
   );

   // Longer gate so retrigger-while-high is reachable at the minimum tempo.
   step_scheduler #(.STEPS(STEPS), .TRACKS(TRACKS), .GATE_CYCLES(G2), .MIN_TICKS(MINT)) dut_b (
      .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .tempo_ticks(tempo_ticks),
      .wr_en(wr_en), .wr_track(wr_track), .wr_step(wr_step), .wr_val(wr_val),
      .rd_step(rd_step), .rd_col(rd_col_b), .step_idx(step_idx_b), .step_strobe(step_strobe_b),
      .trig(trig_b), .gate(gate_b), .playing(playing_b)
   );

   // Behavioural model state
   bit                m_pat [TRACKS][STEPS];
   int                m_step, m_phase, m_period;
   bit                m_play, m_strobe, m_valid;
   logic [TRACKS-1:0] m_trig, m_rd;
   int                grem [2][TRACKS];
   logic [SW-1:0]     exp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp(input logic [23:0] t);
      return (int'(t) < MINT) ? MINT : int'(t);
   endfunction

   task automatic model_edge();
      bit old_pat [TRACKS][STEPS];
      if (reset) begin
         for (int t = 0; t < TRACKS; t++) begin
            for (int s = 0; s < STEPS; s++) m_pat[t][s] = 1'b0;
            grem[0][t] = 0;
            grem[1][t] = 0;
         end
         m_step = 0; m_phase = 0; m_period = MINT;
         m_play = 0; m_strobe = 0; m_trig = '0; m_rd = '0;
         m_valid = 1;
         exp_q.delete();
         return;
      end
      old_pat = m_pat;
      if (wr_en) m_pat[wr_track][wr_step] = wr_val;
      for (int t = 0; t < TRACKS; t++) m_rd[t] = old_pat[t][rd_step];
      m_strobe = 0;
      m_trig   = '0;
      if (!m_play) begin
         if (run) begin
            m_play = 1; m_step = 0; m_phase = 0;
            m_period = clamp(tempo_ticks);
            m_strobe = 1;
         end
      end else if (!run) begin
         m_play = 0;
         for (int t = 0; t < TRACKS; t++) begin
            grem[0][t] = 0;
            grem[1][t] = 0;
         end
      end else begin
         m_phase++;
         if (m_phase == m_period) begin
            m_phase  = 0;
            m_step   = (m_step + 1) % STEPS;
            m_period = clamp(tempo_ticks);
            m_strobe = 1;
         end
      end
      if (m_strobe) begin
         exp_q.push_back(m_step[SW-1:0]);
         for (int t = 0; t < TRACKS; t++) m_trig[t] = old_pat[t][m_step];
      end
      for (int g = 0; g < 2; g++) begin
         for (int t = 0; t < TRACKS; t++) begin
            if (m_trig[t]) grem[g][t] = (g == 0) ? G1 : G2;
            else if (grem[g][t] > 0) grem[g][t]--;
         end
      end
   endtask

   task automatic compare();
      logic [TRACKS-1:0] g1, g2;
      if (!m_valid) return;
      for (int t = 0; t < TRACKS; t++) begin
         g1[t] = (grem[0][t] > 0);
         g2[t] = (grem[1][t] > 0);
      end
      chk("step_strobe", step_strobe, m_strobe);
      chk("trig", trig, m_trig);
      chk("gate", gate, g1);
      chk("gate_b", gate_b, g2);
      chk("playing", playing, m_play);
      chk("step_idx", step_idx, m_step[SW-1:0]);
      chk("rd_col", rd_col, m_rd);
      chk("dut_b_misc", {rd_col_b, step_idx_b, step_strobe_b, trig_b, playing_b},
          {m_rd, m_step[SW-1:0], m_strobe, m_trig, m_play});
      if (step_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL strobe_queue actual=strobe expected=no_strobe t=%0t", $time);
         end else begin
            chk("strobe_step", step_idx, exp_q.pop_front());
         end
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      compare();
   endtask

   task automatic write(input int tr, input int st, input bit v);
      wr_en = 1'b1; wr_track = 1'(tr); wr_step = SW'(st); wr_val = v;
      tick();
      wr_en = 1'b0;
   endtask

   logic [1:0] lit_trig [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
   bit         lit_t0   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int saved, s;
      bit old;
      m_valid = 0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (20) tick();
      for (int r = 0; r < STEPS; r++) begin
         rd_step = SW'(r);
         tick();
         chk("reset_rd_col", rd_col, 0);
      end

      // Pattern t0={1,0,1,0}, t1={0,1,0,0}; tempo 10
      write(0, 0, 1'b1);
      write(0, 2, 1'b1);
      write(1, 1, 1'b1);
      tempo_ticks = 24'd10;
      run = 1'b1;
      tick();
      chk("start_strobe", step_strobe, 1);
      chk("start_playing", playing, 1);
      chk("start_trig", trig, 2'b01);
      chk("start_step", step_idx, 0);
      chk("start_gate", gate, 2'b01);
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i % 10 == 0) begin
            chk("seq_strobe", step_strobe, 1);
            chk("seq_trig", trig, lit_trig[(i / 10) % 4]);
            chk("seq_step", step_idx, (i / 10) % 4);
         end else begin
            chk("seq_no_strobe", step_strobe, 0);
         end
         if (i == 2) chk("gate0_last", gate[0], 1);
         if (i == 3) chk("gate0_off", gate[0], 0);
      end

      // Tempo change mid-step only applies at the next boundary
      repeat (5) tick();
      tempo_ticks = 24'd6;
      repeat (5) tick();
      chk("tempo_old_len", step_strobe, 1);
      chk("tempo_old_step", step_idx, 1);
      repeat (5) tick();
      chk("tempo6_mid", step_strobe, 0);
      tempo_ticks = 24'd2;
      tick();
      chk("tempo6_len", step_strobe, 1);
      chk("tempo6_step", step_idx, 2);
      repeat (3) tick();
      chk("clamp_mid", step_strobe, 0);
      tick();
      chk("clamp_len", step_strobe, 1);
      chk("clamp_step", step_idx, 3);

      // Track 1 active on every step at 4-cycle steps
      for (int k = 0; k < STEPS; k++) write(1, k, 1'b1);
      tick();
      for (int k = 0; k < 8 && !m_strobe; k++) tick();
      for (int i = 0; i < 16; i++) begin
         chk("gate_b_continuous", gate_b[1], 1);
         if (i % 4 == 3) chk("gate1_gap", gate[1], 0);
         else chk("gate1_on", gate[1], 1);
         tick();
      end

      // Stop exactly at a boundary
      for (int k = 0; k < 8 && m_phase != m_period - 1; k++) tick();
      saved = m_step;
      run = 1'b0;
      tick();
      chk("stop_playing", playing, 0);
      chk("stop_trig", trig, 0);
      chk("stop_strobe", step_strobe, 0);
      chk("stop_gate", gate, 0);
      chk("stop_gate_b", gate_b, 0);
      chk("stop_hold_step", step_idx, saved);
      repeat (5) tick();
      run = 1'b1;
      tick();
      chk("restart_step", step_idx, 0);
      chk("restart_strobe", step_strobe, 1);
      chk("restart_playing", playing, 1);

      // Write to the step being triggered in the same cycle
      for (int k = 0; k < 8 && m_phase != m_period - 1; k++) tick();
      s = (m_step + 1) % STEPS;
      old = lit_t0[s];
      wr_en = 1'b1; wr_track = 1'b0; wr_step = SW'(s); wr_val = !old;
      rd_step = SW'(s);
      tick();
      wr_en = 1'b0;
      chk("wr_same_cycle_trig", trig[0], old);
      tick();
      chk("rd_after_write", rd_col[0], !old);

      // Reset in the middle of RUN
      reset = 1'b1;
      tick();
      chk("rst_run_outputs", {rd_col, step_idx, step_strobe, trig, gate, playing}, 0);
      reset = 1'b0;
      run = 1'b0;
      tick();

      // Randomized traffic
      run = 1'b1;
      for (int c = 0; c < 1200; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) run = !run;
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_track = 1'($urandom_range(0, 1));
         wr_step  = SW'($urandom_range(0, STEPS - 1));
         wr_val   = 1'($urandom_range(0, 1));
         rd_step  = SW'($urandom_range(0, STEPS - 1));
         if ($urandom_range(0, 29) == 0) tempo_ticks = 24'($urandom_range(0, 12));
         tick();
      end
      reset = 1'b0;
      wr_en = 1'b0;
      chk("strobe_queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
